myproject_dot_accum: RTL and testbench

- Downstream consumer of the 16s x 11ns -> 27-bit signed product multiplier in the HEPT kernel datapath.
- Accumulates N_TERMS consecutive signed products, one per accepted beat, into a wide accumulator.
- Requantises the sum by round-half-up right shift with signed saturation to OUT_W bits.
- Emits one result per vector on a valid/ready output stream.

---
 rtl/myproject_dot_pkg.sv | 23 ++
 rtl/myproject_round_sat.sv | 43 ++++
 rtl/myproject_dot_accum.sv | 80 ++++++++
 tb/tb_myproject_dot_accum.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_dot_pkg.sv
// Shared widths, derived limits and signed types for the dot-product
// accumulate and requantise datapath.
package myproject_dot_pkg;

    localparam int PROD_W   = 27;
    localparam int N_TERMS  = 16;
    localparam int ACC_W    = 32;
    localparam int SHIFT    = 10;
    localparam int OUT_W    = 16;

    localparam int OUT_MAX  = 2 ** (OUT_W - 1) - 1;
    localparam int OUT_MIN  = -(2 ** (OUT_W - 1));
    localparam int RND_HALF = 2 ** (SHIFT - 1);

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0]  out_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Round-half-up right shift of a wide signed sum, then signed
// saturation to the output width with an overflow flag.
module myproject_round_sat #(
    parameter int ACC_W = myproject_dot_pkg::ACC_W,
    parameter int SHIFT = myproject_dot_pkg::SHIFT,
    parameter int OUT_W = myproject_dot_pkg::OUT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam logic signed [ACC_W:0] RNDV =
        {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    // one guard bit keeps the rounding add from wrapping
    assign sum = $signed({acc[ACC_W-1], acc}) + RNDV;
    assign r   = sum >>> SHIFT;

    always_comb begin
        dout = r[OUT_W-1:0];
        ovf  = 1'b0;
        unique case (1'b1)
            (r > MAXV): begin
                dout = MAXV[OUT_W-1:0];
                ovf  = 1'b1;
            end
            (r < MINV): begin
                dout = MINV[OUT_W-1:0];
                ovf  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/myproject_dot_accum.sv
// Accumulates N_TERMS signed products per vector and emits one
// requantised, saturated result per vector on a valid/ready stream.
module myproject_dot_accum #(
    parameter int PROD_W  = myproject_dot_pkg::PROD_W,
    parameter int N_TERMS = myproject_dot_pkg::N_TERMS,
    parameter int ACC_W   = myproject_dot_pkg::ACC_W,
    parameter int SHIFT   = myproject_dot_pkg::SHIFT,
    parameter int OUT_W   = myproject_dot_pkg::OUT_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_din,
    input  logic                     prod_vld,
    output logic                     prod_rdy,
    output logic signed [OUT_W-1:0]  out_dout,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_ovf
);

    import myproject_dot_pkg::*;

    localparam int CW = cnt_w(N_TERMS);
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

    if (N_TERMS < 1 || SHIFT < 1 ||
        ACC_W < PROD_W + $clog2(N_TERMS)) begin : g_param_chk
        $error("myproject_dot_accum: illegal parameters");
    end

    logic [CW-1:0]            cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  rs_dout;
    logic                     rs_ovf;
    logic                     last;
    logic                     accept;

    assign last     = (cnt == LAST);
    assign prod_rdy = ~(out_vld & last);
    assign accept   = prod_vld & prod_rdy;
    assign prod_ext =
        {{(ACC_W - PROD_W){prod_din[PROD_W-1]}}, prod_din};
    assign acc_next =
        ((cnt == '0) ? '0 : acc) + prod_ext;

    myproject_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc  (acc_next),
        .dout (rs_dout),
        .ovf  (rs_ovf)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc      <= '0;
            cnt      <= '0;
            out_vld  <= 1'b0;
            out_dout <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (out_vld && out_rdy)
                out_vld <= 1'b0;
            if (accept) begin
                acc <= acc_next;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    out_vld  <= 1'b1;
                    out_dout <= rs_dout;
                    out_ovf  <= rs_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_myproject_dot_accum.sv
// Self-checking bench: directed vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference.
module tb_myproject_dot_accum;

    import myproject_dot_pkg::*;

    logic  ap_clk = 1'b0;
    logic  ap_rst;
    prod_t prod_din;
    logic  prod_vld;
    logic  prod_rdy;
    out_t  out_dout;
    logic  out_vld;
    logic  out_rdy;
    logic  out_ovf;

    int tests = 0;
    int fails = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_dot_accum dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .prod_din (prod_din),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .out_dout (out_dout),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_ovf  (out_ovf)
    );

    typedef struct {
        string  name;
        longint fill;
        longint fin;
        longint exp_dout;
        bit     exp_ovf;
    } vec_t;

    vec_t   vecs[7];
    longint beats[$];
    longint expd[$];
    bit     expo[$];

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference: exact sum, floor((s + half) / 2^SHIFT), clamp
    function automatic void mdl(input longint s,
                                output longint d, output bit o);
        longint r;
        r = (s + longint'(RND_HALF)) >>> SHIFT;
        o = 1'b1;
        if (r > OUT_MAX)      d = OUT_MAX;
        else if (r < OUT_MIN) d = OUT_MIN;
        else begin
            d = r;
            o = 1'b0;
        end
    endfunction

    task automatic send(input longint v);
        int n = 0;
        prod_din = prod_t'(v);
        prod_vld = 1'b1;
        while (!prod_rdy && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: prod_rdy stuck at 0");
        end
        @(posedge ap_clk);
        #1;
        prod_vld = 1'b0;
    endtask

    function automatic longint rnd_prod();
        prod_t p;
        if ($urandom % 3 == 0) begin
            p = prod_t'($urandom);
            return longint'(p);
        end
        return longint'($urandom_range(6000)) - 3000;
    endfunction

    initial begin
        longint s, d;
        bit     o;

        vecs[0] = '{"basic",     1024, 1024, 16, 0};
        vecs[1] = '{"rnd_p512",  0, 512, 1, 0};
        vecs[2] = '{"rnd_m512",  0, -512, 0, 0};
        vecs[3] = '{"rnd_m513",  0, -513, -1, 0};
        vecs[4] = '{"rnd_p511",  0, 511, 0, 0};
        vecs[5] = '{"sat_pos",   (1 << 26) - 1, (1 << 26) - 1,
                    32767, 1};
        vecs[6] = '{"sat_neg",   -(1 << 26), -(1 << 26),
                    -32768, 1};

        ap_rst   = 1'b1;
        prod_vld = 1'b0;
        prod_din = '0;
        out_rdy  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_vld = 1'($urandom);
            prod_din = prod_t'($urandom);
            out_rdy  = 1'($urandom);
            @(posedge ap_clk);
            #1;
            chk("rst_vld", out_vld, 0);
            chk("rst_dout", out_dout, 0);
            chk("rst_ovf", out_ovf, 0);
        end
        ap_rst   = 1'b0;
        prod_vld = 1'b0;
        out_rdy  = 1'b1;
        chk("rst_rdy", prod_rdy, 1);

        foreach (vecs[i]) begin
            for (int k = 0; k < N_TERMS; k++) begin
                send(k == N_TERMS - 1 ? vecs[i].fin : vecs[i].fill);
                if (k == N_TERMS - 2)
                    chk({vecs[i].name, "_early"}, out_vld, 0);
            end
            chk({vecs[i].name, "_vld"}, out_vld, 1);
            chk({vecs[i].name, "_dout"}, out_dout, vecs[i].exp_dout);
            chk({vecs[i].name, "_ovf"}, out_ovf, vecs[i].exp_ovf);
            @(posedge ap_clk);
            #1;
            chk({vecs[i].name, "_1cyc"}, out_vld, 0);
        end

        for (int k = 0; k < N_TERMS; k++) send(2048);
        chk("bp_a_dout", out_dout, 32);
        out_rdy = 1'b0;
        for (int k = 0; k < N_TERMS - 1; k++) send(1024);
        chk("bp_a_vld", out_vld, 1);
        chk("bp_a_hold", out_dout, 32);
        prod_din = prod_t'(1024);
        prod_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            chk("bp_stall_rdy", prod_rdy, 0);
            chk("bp_stall_dout", out_dout, 32);
            chk("bp_stall_ovf", out_ovf, 0);
        end
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        out_rdy = 1'b0;
        chk("bp_a_taken", out_vld, 0);
        chk("bp_rdy_back", prod_rdy, 1);
        @(posedge ap_clk);
        #1;
        prod_vld = 1'b0;
        chk("bp_b_vld", out_vld, 1);
        chk("bp_b_dout", out_dout, 16);
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("bp_b_taken", out_vld, 0);

        for (int k = 0; k < 7; k++) send(5000);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int k = 0; k < N_TERMS; k++) begin
            send(1024);
            if (k == 8) chk("mrst_nowrap", out_vld, 0);
        end
        chk("mrst_vld", out_vld, 1);
        chk("mrst_dout", out_dout, 16);
        @(posedge ap_clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge ap_clk);
            prod_vld = (c < 2800) && ($urandom % 4 != 0);
            prod_din = prod_t'(rnd_prod());
            out_rdy  = (c >= 2800) || ($urandom % 3 != 0);
            #1;
            chk("rnd_vld", out_vld, expd.size() != 0);
            chk("rnd_rdy", prod_rdy,
                !(expd.size() != 0 && beats.size() == N_TERMS - 1));
            if (out_vld && out_rdy) begin
                if (expd.size() == 0) begin
                    chk("rnd_extra", 1, 0);
                end else begin
                    chk("rnd_dout", out_dout, expd.pop_front());
                    chk("rnd_ovf", out_ovf, expo.pop_front());
                end
            end
            if (prod_vld && prod_rdy) begin
                beats.push_back(longint'(prod_din));
                if (beats.size() == N_TERMS) begin
                    s = 0;
                    foreach (beats[j]) s += beats[j];
                    mdl(s, d, o);
                    expd.push_back(d);
                    expo.push_back(o);
                    beats.delete();
                end
            end
        end
        chk("rnd_drained", expd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
